// File: rtl/pool_window_2x2.sv
// pool_window_2x2: turns a raster-scanned feature map into non-overlapping
// 2x2 windows (stride 2) for the pooling stage downstream.
// Even rows are parked in a one-row line buffer. On odd rows, the even-column
// pixel is held, and the odd-column pixel completes the window.
module pool_window_2x2 #(
  parameter int WIDTH = 32,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIDTH-1:0] x00,
  output logic [WIDTH-1:0] x01,
  output logic [WIDTH-1:0] x10,
  output logic [WIDTH-1:0] x11,
  output logic             win_last
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [WIDTH-1:0] hold_x10;
  logic [WIDTH-1:0] linebuf [IMG_W];
  logic             accept;
  logic [CW-1:0]    col_even;

  // A beat moves only when the output slot is free or is being drained now.
  // This also stalls beats that will not complete a window, which keeps the
  // handshake simple.
  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  // col is odd when a window completes, so its left neighbour is col with bit 0 cleared.
  assign col_even = {col[CW-1:1], 1'b0};

  // Upper row of each window. This buffer is never read before an even row
  // rewrites it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept && !row[0]) linebuf[col] <= in_data;
  end

  // Raster counters, odd-row hold register, and registered window output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      hold_x10  <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      x00       <= '0;
      x01       <= '0;
      x10       <= '0;
      x11       <= '0;
    end else begin
      if (win_valid && win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (row[0] && !col[0]) hold_x10 <= in_data;
        if (row[0] && col[0]) begin
          x00       <= linebuf[col_even];
          x01       <= linebuf[col];
          x10       <= hold_x10;
          x11       <= in_data;
          win_valid <= 1'b1;
          win_last  <= (row == ROW_LAST) && (col == COL_LAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_window_2x2.sv
// Directed bench for pool_window_2x2 on a 4x4 frame: basic frame, Q2.30 data,
// backpressure, bubbles, back-to-back frames and mid-frame reset.
module tb_pool_window_2x2;

  localparam int WIDTH = 32;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             win_valid;
  logic             win_ready;
  logic [WIDTH-1:0] x00, x01, x10, x11;
  logic             win_last;

  pool_window_2x2 #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .win_valid(win_valid), .win_ready(win_ready),
    .x00(x00), .x01(x01), .x10(x10), .x11(x11), .win_last(win_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a, b, c, d;
    logic             last;
    int               cyc;
  } win_t;

  win_t             q[$];
  int               cyc = 0;
  int               n_tests = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] pix [0:63];
  int               acc_cyc [0:63];
  // Pixel offsets within a 4x4 frame for windows 0..3.
  int               ofs [0:3][0:3] = '{'{0,1,4,5}, '{2,3,6,7}, '{8,9,12,13}, '{10,11,14,15}};

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every consumed window. The inputs are stable from posedge+1 through the next posedge.
  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready)
      q.push_back('{a: x00, b: x01, c: x10, d: x11, last: win_last, cyc: cyc});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive pix[0..n-1] in order; with bubble, an idle cycle follows each accepted beat.
  task automatic send(input int n, input bit bubble);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = pix[i];
      @(negedge clk);
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) chk($sformatf("send_timeout_px%0d", i), {63'd0, in_ready}, 64'd1);
      acc_cyc[i] = cyc + 1;
      if (bubble) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic fill(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) pix[i] = base + WIDTH'(i);
  endtask

  // Check four windows starting at q[qi] against a 4x4 frame whose first pixel is base.
  task automatic expect_frame(input string tag, input int qi, input logic [WIDTH-1:0] base);
    for (int k = 0; k < 4; k++) begin
      if (qi + k >= q.size()) begin
        chk($sformatf("%s_w%0d_count", tag, k), 64'(q.size()), 64'(qi + k + 1));
      end else begin
        chk($sformatf("%s_w%0d_x00", tag, k), 64'(q[qi+k].a), 64'(base + WIDTH'(ofs[k][0])));
        chk($sformatf("%s_w%0d_x01", tag, k), 64'(q[qi+k].b), 64'(base + WIDTH'(ofs[k][1])));
        chk($sformatf("%s_w%0d_x10", tag, k), 64'(q[qi+k].c), 64'(base + WIDTH'(ofs[k][2])));
        chk($sformatf("%s_w%0d_x11", tag, k), 64'(q[qi+k].d), 64'(base + WIDTH'(ofs[k][3])));
        chk($sformatf("%s_w%0d_last", tag, k), 64'(q[qi+k].last), (k == 3) ? 64'd1 : 64'd0);
      end
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    win_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_win_valid", 64'(win_valid), 64'd0);
    chk("rst_win_last", 64'(win_last), 64'd0);
    chk("rst_x00", 64'(x00), 64'd0);
    chk("rst_x11", 64'(x11), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic frame, with latency: each window is seen in the cycle its bottom-right pixel is accepted.
    q.delete();
    fill(16, 0);
    send(16, 0);
    drain();
    chk("basic_count", 64'(q.size()), 64'd4);
    expect_frame("basic", 0, 0);
    if (q.size() == 4) begin
      chk("basic_lat_w0", 64'(q[0].cyc), 64'(acc_cyc[5]));
      chk("basic_lat_w1", 64'(q[1].cyc), 64'(acc_cyc[7]));
      chk("basic_lat_w2", 64'(q[2].cyc), 64'(acc_cyc[13]));
      chk("basic_lat_w3", 64'(q[3].cyc), 64'(acc_cyc[15]));
    end

    // Q2.30 bit patterns pass through unchanged.
    q.delete();
    fill(16, 0);
    pix[0] = 32'h4000_0000; pix[1] = 32'h2000_0000;
    pix[4] = 32'hC000_0000; pix[5] = 32'h0000_0001;
    send(16, 0);
    drain();
    chk("q230_count", 64'(q.size()), 64'd4);
    if (q.size() > 0) begin
      chk("q230_x00", 64'(q[0].a), 64'h4000_0000);
      chk("q230_x01", 64'(q[0].b), 64'h2000_0000);
      chk("q230_x10", 64'(q[0].c), 64'hC000_0000);
      chk("q230_x11", 64'(q[0].d), 64'h0000_0001);
    end

    // Backpressure: hold the first window for 3 cycles.
    q.delete();
    fill(16, 0);
    fork
      send(16, 0);
      begin
        int t = 0;
        @(posedge clk); #1;
        while (!win_valid && t < 100) begin
          @(posedge clk); #1;
          t++;
        end
        chk("bp_window_seen", 64'(win_valid), 64'd1);
        win_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk($sformatf("bp_in_ready_c%0d", k), 64'(in_ready), 64'd0);
          chk($sformatf("bp_valid_c%0d", k), 64'(win_valid), 64'd1);
          chk($sformatf("bp_win_c%0d", k), {x00[15:0], x01[15:0], x10[15:0], x11[15:0]},
              64'h0000_0001_0004_0005);
          @(posedge clk); #1;
        end
        win_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(q.size()), 64'd4);
    expect_frame("bp", 0, 0);

    // Bubbles on every other cycle.
    q.delete();
    fill(16, 0);
    send(16, 1);
    drain();
    chk("bub_count", 64'(q.size()), 64'd4);
    expect_frame("bub", 0, 0);

    // Back-to-back frames with no gap.
    q.delete();
    fill(32, 0);
    send(32, 0);
    drain();
    chk("b2b_count", 64'(q.size()), 64'd8);
    expect_frame("b2b_f0", 0, 0);
    expect_frame("b2b_f1", 4, 16);

    // Mid-frame reset while a window (0,1,4,5) is still pending.
    q.delete();
    win_ready = 1'b0;
    fill(6, 0);
    send(6, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_win_valid", 64'(win_valid), 64'd0);
    chk("mrst_x00", 64'(x00), 64'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    win_ready = 1'b1;
    fill(16, 100);
    send(16, 0);
    drain();
    chk("mrst_count", 64'(q.size()), 64'd4);
    expect_frame("mrst", 0, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Keep the run bounded even if a handshake never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
